// File: rtl/nic_arb_pkg.sv
// Shared types and constants for the NIC register-port arbiter.
package nic_arb_pkg;

  localparam int unsigned NIC_DW = 64;

  localparam logic [1:0] NIC_ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_PCAP,
    ST_XFER,
    ST_XCAP,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts at ptr_i and wraps.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  logic [IW:0]   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      cand_idx = cand[IW-1:0];
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/nic_port_arbiter.sv
// Shares the NIC register port among NUM_REQ requesters with poll-then-access sequencing.
// Optional poll timeout with error completion: define NIC_ARB_TIMEOUT_EN.
module nic_port_arbiter
  import nic_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned RETRY_MAX = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*NIC_DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic [NIC_DW-1:0]         rdata,
  output logic                      nic_en,
  output logic                      nic_wr_en,
  output logic [1:0]                nic_addr,
  output logic [NIC_DW-1:0]         nic_wdata,
  input  logic [NIC_DW-1:0]         nic_rdata
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  win_oh_q, win_oh_d;
  logic [IW-1:0]       win_idx_q, win_idx_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic                wr_q, wr_d;
  logic [NIC_DW-1:0]   wdata_q, wdata_d;
  logic [NIC_DW-1:0]   rdata_q, rdata_d;
  logic                stat_ok;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

`ifdef NIC_ARB_TIMEOUT_EN
  localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  assign err = (state_q == ST_DONE) && err_q;
`else
  localparam int unsigned unused_retry_max = RETRY_MAX;

  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      win_oh_q  <= '0;
      win_idx_q <= '0;
      ptr_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      win_oh_q  <= win_oh_d;
      win_idx_q <= win_idx_d;
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_oh_d  = win_oh_q;
    win_idx_d = win_idx_q;
    ptr_d     = ptr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifdef NIC_ARB_TIMEOUT_EN
    retry_d   = retry_q;
    err_d     = err_q;
`endif
    nic_en    = 1'b0;
    nic_wr_en = 1'b0;
    nic_addr  = NIC_ADDR_IN_DATA;
    nic_wdata = '0;
    // Reads wait for a full input buffer, writes for a non-full output buffer.
    stat_ok   = wr_q ? ~nic_rdata[0] : nic_rdata[0];

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_oh_d  = arb_gnt;
          win_idx_d = arb_idx;
          wr_d      = |(req_wr & arb_gnt);
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
              wdata_d = req_wdata[i*NIC_DW +: NIC_DW];
            end
          end
`ifdef NIC_ARB_TIMEOUT_EN
          retry_d = '0;
          err_d   = 1'b0;
`endif
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        nic_en   = 1'b1;
        nic_addr = wr_q ? NIC_ADDR_OUT_STAT : NIC_ADDR_IN_STAT;
        state_d  = ST_PCAP;
      end
      ST_PCAP: begin
        if (stat_ok) begin
          state_d = ST_XFER;
        end
`ifdef NIC_ARB_TIMEOUT_EN
        else if (retry_q == RW'(RETRY_MAX)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = ST_POLL;
        end
`else
        else begin
          state_d = ST_POLL;
        end
`endif
      end
      ST_XFER: begin
        nic_en    = 1'b1;
        nic_wr_en = wr_q;
        nic_addr  = wr_q ? NIC_ADDR_OUT_DATA : NIC_ADDR_IN_DATA;
        nic_wdata = wr_q ? wdata_q : '0;
        state_d   = ST_XCAP;
      end
      ST_XCAP: begin
        if (!wr_q) begin
          rdata_d = nic_rdata;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        ptr_d   = (win_idx_q == IW'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant = (state_q != ST_IDLE) ? win_oh_q : '0;
  assign ack   = (state_q == ST_DONE) ? win_oh_q : '0;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_nic_port_arbiter.sv
// Directed bench for nic_port_arbiter with a small NIC model and an ack scoreboard.
module tb_nic_port_arbiter;

  localparam int unsigned NR = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req, req_wr, grant, ack;
  logic [NR*64-1:0] req_wdata;
  logic            err;
  logic [63:0]     rdata, nic_wdata;
  logic [63:0]     nic_rdata = '0;
  logic            nic_en, nic_wr_en;
  logic [1:0]      nic_addr;

  nic_port_arbiter #(.NUM_REQ(NR), .RETRY_MAX(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_wr    (req_wr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .nic_en    (nic_en),
    .nic_wr_en (nic_wr_en),
    .nic_addr  (nic_addr),
    .nic_wdata (nic_wdata),
    .nic_rdata (nic_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // NIC model: registered read data, output status full for the first polls below out_busy_lim.
  logic        in_full;
  logic [63:0] in_data;
  int          out_polls = 0;
  int          out_busy_lim;

  always @(posedge clk) begin
    if (nic_en && !nic_wr_en) begin
      case (nic_addr)
        2'b00: nic_rdata <= in_data;
        2'b01: nic_rdata <= {63'd0, in_full};
        2'b11: begin
          nic_rdata <= {63'd0, (out_polls < out_busy_lim)};
          out_polls <= out_polls + 1;
        end
        default: ;
      endcase
    end
  end

  int          acc_cyc[$];
  logic [1:0]  acc_addr[$];
  logic        acc_wr[$];
  logic [63:0] acc_wd[$];

  always @(negedge clk) begin
    if (nic_en) begin
      acc_cyc.push_back(cyc);
      acc_addr.push_back(nic_addr);
      acc_wr.push_back(nic_wr_en);
      acc_wd.push_back(nic_wdata);
    end
  end

  typedef struct packed {
    logic [NR-1:0] vec;
    logic          e;
    logic [63:0]   data;
    int            c;
  } ack_t;

  ack_t obs[$];
  ack_t sb[$];
  int   rd_idx = 0;

  always @(negedge clk) begin
    if (reset_n && ack != '0) obs.push_back('{ack, err, rdata, cyc});
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] x);
    total++;
    assert (o === x) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, x);
    end
  endtask

  task automatic expect_ack(input logic [NR-1:0] v, input logic e, input logic [63:0] d, input int c);
    ack_t a;
    a.vec = v; a.e = e; a.data = d; a.c = c;
    sb.push_back(a);
  endtask

  task automatic drain();
    ack_t o, x;
    while (rd_idx < obs.size()) begin
      o = obs[rd_idx];
      rd_idx++;
      if (sb.size() == 0) begin
        check("unexpected_ack", 64'(o.vec), 64'd0);
      end else begin
        x = sb.pop_front();
        check($sformatf("ack_vec#%0d", rd_idx), 64'(o.vec), 64'(x.vec));
        check($sformatf("ack_err#%0d", rd_idx), 64'(o.e), 64'(x.e));
        check($sformatf("ack_rdata#%0d", rd_idx), o.data, x.data);
        check($sformatf("ack_cycle#%0d", rd_idx), 64'(o.c), 64'(x.c));
      end
    end
  endtask

  task automatic wait_obs(input int target, input int budget);
    int i = 0;
    while (obs.size() < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    check("ack_wait", 64'(obs.size() >= target), 64'd1);
    #1;
  endtask

  int c0, a0, n0, cnt;

  initial begin
    reset_n = 1'b0; req = '0; req_wr = '0; req_wdata = '0;
    in_full = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001; out_busy_lim = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({grant, ack, err, nic_en, nic_wr_en, nic_addr}), 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_nic_wdata", nic_wdata, 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Read with input already full
    c0 = cyc; a0 = acc_cyc.size(); n0 = obs.size();
    expect_ack(2'b01, 1'b0, 64'hDEAD_BEEF_0000_0001, c0 + 5);
    req[0] = 1'b1;
    wait_obs(n0 + 1, 40);
    req[0] = 1'b0;
    drain();
    check("rd_acc_count", 64'(acc_cyc.size() - a0), 64'd2);
    check("rd_poll_addr", 64'(acc_addr[a0]), 64'd1);
    check("rd_poll_cyc", 64'(acc_cyc[a0]), 64'(c0 + 1));
    check("rd_pop_addr", 64'(acc_addr[a0+1]), 64'd0);
    check("rd_pop_cyc", 64'(acc_cyc[a0+1]), 64'(c0 + 3));
    check("rd_no_wr", 64'({acc_wr[a0], acc_wr[a0+1]}), 64'd0);

    // Write with output full for three polls
    out_busy_lim = out_polls + 3;
    req_wdata[127:64] = 64'h8000_0000_0000_00AA;
    req_wr[1] = 1'b1;
    c0 = cyc; a0 = acc_cyc.size(); n0 = obs.size();
    expect_ack(2'b10, 1'b0, 64'hDEAD_BEEF_0000_0001, c0 + 11);
    req[1] = 1'b1;
    wait_obs(n0 + 1, 60);
    req[1] = 1'b0; req_wr[1] = 1'b0;
    drain();
    check("wr_acc_count", 64'(acc_cyc.size() - a0), 64'd5);
    cnt = 0;
    for (int i = 0; i < 4; i++) if (acc_addr[a0+i] == 2'b11 && !acc_wr[a0+i]) cnt++;
    check("wr_poll_count", 64'(cnt), 64'd4);
    check("wr_push_addr", 64'(acc_addr[a0+4]), 64'd2);
    check("wr_push_we", 64'(acc_wr[a0+4]), 64'd1);
    check("wr_push_data", acc_wd[a0+4], 64'h8000_0000_0000_00AA);
    check("wr_push_cyc", 64'(acc_cyc[a0+4]), 64'(c0 + 9));

    // Contention, both requesters held
    in_data = 64'h1111_2222_3333_4444;
    c0 = cyc; n0 = obs.size();
    expect_ack(2'b01, 1'b0, in_data, c0 + 5);
    expect_ack(2'b10, 1'b0, in_data, c0 + 11);
    expect_ack(2'b01, 1'b0, in_data, c0 + 17);
    expect_ack(2'b10, 1'b0, in_data, c0 + 23);
    req = 2'b11;
    @(posedge clk); #1;
    check("cont_grant_first", 64'(grant), 64'd1);
    wait_obs(n0 + 4, 100);
    req = '0;
    drain();

`ifdef NIC_ARB_TIMEOUT_EN
    // Timeout: input status stuck empty
    in_full = 1'b0;
    c0 = cyc; a0 = acc_cyc.size(); n0 = obs.size();
    expect_ack(2'b01, 1'b1, 64'h1111_2222_3333_4444, c0 + 9);
    req[0] = 1'b1;
    wait_obs(n0 + 1, 60);
    req[0] = 1'b0;
    drain();
    check("to_acc_count", 64'(acc_cyc.size() - a0), 64'd4);
    cnt = 0;
    for (int i = a0; i < acc_cyc.size(); i++) if (acc_addr[i] == 2'b01) cnt++;
    check("to_poll_count", 64'(cnt), 64'd4);
    in_full = 1'b1;
`endif

    // Requester drops req in cycle 2
    in_data = 64'h0123_4567_89AB_CDEF;
    c0 = cyc; a0 = acc_cyc.size(); n0 = obs.size();
    expect_ack(2'b01, 1'b0, 64'h0123_4567_89AB_CDEF, c0 + 5);
    req[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req[0] = 1'b0;
    wait_obs(n0 + 1, 40);
    drain();
    check("drop_poll_addr", 64'(acc_addr[a0]), 64'd1);
    check("drop_pop_cyc", 64'(acc_cyc[a0+1]), 64'(c0 + 3));
    repeat (10) @(posedge clk);
    #1;
    drain();

    // Reset during the write access cycle
    out_busy_lim = out_polls;
    req_wdata[127:64] = 64'h5555_AAAA_5555_AAAA;
    c0 = cyc; a0 = acc_cyc.size(); n0 = obs.size();
    req_wr[1] = 1'b1; req[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_xfer_active", 64'({nic_en, nic_wr_en, nic_addr}), 64'hE);
    reset_n = 1'b0;
    #1;
    check("rst_nic_en", 64'(nic_en), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    req = '0; req_wr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    cnt = 0;
    for (int i = a0; i < acc_cyc.size(); i++) if (acc_addr[i] == 2'b10) cnt++;
    check("rst_no_write", 64'(cnt), 64'd0);
    check("rst_no_ack", 64'(obs.size() - n0), 64'd0);

    // After reset the pointer is back at requester 0
    @(posedge clk); #1;
    c0 = cyc; n0 = obs.size();
    expect_ack(2'b01, 1'b0, 64'h0123_4567_89AB_CDEF, c0 + 5);
    req = 2'b11;
    @(posedge clk); #1;
    check("post_rst_grant", 64'(grant), 64'd1);
    req[1] = 1'b0;
    wait_obs(n0 + 1, 40);
    req = '0;
    repeat (8) @(posedge clk);
    #1;
    drain();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nic_port_arbiter.md
# nic_port_arbiter

Shares the single register port of the network interface controller (enable, write-enable, 2-bit address, 64-bit data in/out) between NUM_REQ processing-element-side requesters. It runs the status-poll-then-access sequence on the NIC for each granted requester. Reads poll the input-channel status, then pop the input buffer. Writes poll the output-channel status, then push the output buffer. A requester therefore never reads an empty buffer or writes a full one. The block sits between the PE-side requesters and the NIC.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- RETRY_MAX, 15: failed status polls tolerated before error completion; only used with timeout compiled in.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level, held until ack.
- req_wr  in  NUM_REQ  1 = write (push output buffer), 0 = read (pop input buffer).
- req_wdata  in  NUM_REQ*64  write data, slice i for requester i, stable while req[i] is high.
- grant  out  NUM_REQ  one-hot, high from acceptance through the ack cycle.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- err  out  1  valid with ack; 1 = timed out, no NIC access performed.
- rdata  out  64  read result, valid with ack for reads; holds its value otherwise.
- nic_en  out  1  to NIC enable.
- nic_wr_en  out  1  to NIC write enable.
- nic_addr  out  2  to NIC address.
- nic_wdata  out  64  to NIC data-in.
- nic_rdata  in  64  from NIC data-out; registered in the NIC, valid one cycle after a read access.

## Operation
- NIC addresses:
  - 00: pop input data.
  - 01: input status; bit0 = 1 means full.
  - 10: push output data.
  - 11: output status; bit0 = 1 means full.
- FSM states: IDLE, POLL, PCAP, XFER, XCAP, DONE.
- IDLE: if any req is high, the round-robin arbiter picks a winner, latches its index, type and wdata, sets grant, clears retry_cnt, and moves to POLL.
- POLL: drive nic_en=1, nic_wr_en=0, nic_addr=01 (read) or 11 (write); move to PCAP.
- PCAP: sample nic_rdata[0].
  - Read proceeds to XFER if bit0 = 1.
  - Write proceeds to XFER if bit0 = 0.
  - Otherwise retry_cnt increments and the FSM returns to POLL.
- XFER:
  - Read: nic_en=1, nic_wr_en=0, nic_addr=00.
  - Write: nic_en=1, nic_wr_en=1, nic_addr=10, nic_wdata = latched wdata.
  - Move to XCAP.
- XCAP: for a read, load rdata from nic_rdata; move to DONE.
- DONE: pulse ack[winner], drive err, advance the round-robin pointer to winner+1 (mod NUM_REQ), drop grant, return to IDLE.
- NIC outputs decode from registered state only. nic_en=0, nic_wr_en=0, nic_addr=00 and nic_wdata=0 in every other state.
- Round-robin: the search starts at the pointer. After a winner completes, that requester has lowest priority.
- A requester deasserting req mid-transaction has no effect; the transaction completes and ack still pulses.
- A requester holding req in the cycle after its ack is treated as a new request.
- Status stays stable between poll and access, because this block is the only drainer of the input buffer and the only filler of the output buffer.

## Timing
- Reset values: grant=0, ack=0, err=0, rdata=0, nic_en=0, nic_wr_en=0, nic_addr=00, nic_wdata=0; FSM in IDLE; pointer=0; retry_cnt=0.
- Asserting reset mid-transaction returns to IDLE immediately and drops nic_en asynchronously. No ack is produced for the aborted transaction.
- Successful transaction with the first poll succeeding:
  - req sampled in cycle 0 (IDLE).
  - POLL in cycle 1, PCAP in cycle 2, XFER in cycle 3, XCAP in cycle 4.
  - ack in cycle 5.
  - Next IDLE evaluation in cycle 6.
- Each failed poll adds 2 cycles.
- Throughput: at most one NIC data access every 6 cycles.
- If req rises while the FSM is not in IDLE, the request waits; there is no preemption.

## Configuration
- NIC_ARB_TIMEOUT_EN defined:
  - A failed poll in PCAP with retry_cnt == RETRY_MAX goes directly to DONE with err=1. Total polls are RETRY_MAX+1.
  - No XFER occurs, and rdata is unchanged.
- NIC_ARB_TIMEOUT_EN undefined:
  - The FSM polls indefinitely, err is tied to 0, and the retry counter is removed.

## Structure
- Package nic_arb_pkg holds:
  - the FSM state enum type;
  - the NIC address constants NIC_ADDR_IN_DATA=00, NIC_ADDR_IN_STAT=01, NIC_ADDR_OUT_DATA=10, NIC_ADDR_OUT_STAT=11;
  - the 64-bit data width constant.
- Sub-module rr_arbiter, parameterised by NUM_REQ:
  - inputs: req vector, pointer;
  - outputs: one-hot winner and its binary index (combinational).
- nic_port_arbiter owns the FSM, the latches, the retry counter and the pointer register.

## Test plan
- Read, input already full: NIC model holds input status 1 and data 0xDEAD_BEEF_0000_0001.
  - Required: access sequence addr 01 then 00 in cycles 1 and 3.
  - ack[0] in cycle 5 with rdata=0xDEAD_BEEF_0000_0001, err=0.
- Write, output initially full: status reads 1 for 3 polls, then 0; wdata 0x8000_0000_0000_00AA.
  - Required: 4 polls at addr 11.
  - One write at addr 10 with nic_wr_en=1 and nic_wdata=0x8000_0000_0000_00AA.
  - ack in cycle 11.
- Contention: req=2'b11 held continuously, pointer=0.
  - Required: grant order 0, 1, 0, 1.
  - Ack spacing 6 cycles when all polls succeed.
- Timeout (NIC_ARB_TIMEOUT_EN, RETRY_MAX=3): read with input status stuck at 0.
  - Required: exactly 4 polls, no addr-00 access.
  - ack with err=1; rdata unchanged.
- Reset in cycle 3 of a write: reset_n low.
  - Required: nic_en=0 immediately, no addr-10 write, no ack.
  - grant=0; the next request starts from pointer 0.
- Requester drops req in cycle 2: required ack still pulses in cycle 5 with a correct transfer.
